// File: rtl/draw_rect_bounce.sv
// draw_rect_bounce: overlay stage that paints a solid rectangle over the background
// colour coming from the VGA background generator. The rectangle moves diagonally by
// STEP pixels per frame and bounces off the edges of the active area.
//
// Ports:
//   pclk, rst_n                  pixel clock (rising edge), async active-low reset
//   enable                       1 = rectangle moves once per frame, 0 = frozen
//   hcount_in .. vblnk_in        registered timing bus from the previous stage
//   r_in, g_in, b_in             background colour
//   hcount_out .. vblnk_out      timing bus delayed by one pclk
//   r_out, g_out, b_out          composited colour, registered (same 1-cycle latency)
//   xpos, ypos                   current rectangle left / top edge
module draw_rect_bounce #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned RECT_W     = 64,
    parameter int unsigned RECT_H     = 48,
    parameter logic [11:0] RECT_COLOR = 12'hF70,
    parameter int unsigned STEP       = 2,
    parameter int unsigned INIT_X     = 100,
    parameter int unsigned INIT_Y     = 100
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [3:0]  r_in,
    input  logic [3:0]  g_in,
    input  logic [3:0]  b_in,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [3:0]  r_out,
    output logic [3:0]  g_out,
    output logic [3:0]  b_out,
    output logic [10:0] xpos,
    output logic [10:0] ypos
);

    // Direction encoding: bit 1 = moving up, bit 0 = moving left.
    localparam logic [1:0] DOWN_RIGHT = 2'b00;
    localparam logic [1:0] DOWN_LEFT  = 2'b01;
    localparam logic [1:0] UP_RIGHT   = 2'b10;
    localparam logic [1:0] UP_LEFT    = 2'b11;

    // All position arithmetic is done 12 bits wide so x+W and x+STEP cannot wrap.
    localparam logic [11:0] X_MAX   = 12'(H_ACTIVE - RECT_W);
    localparam logic [11:0] Y_MAX   = 12'(V_ACTIVE - RECT_H);
    localparam logic [11:0] W12     = 12'(RECT_W);
    localparam logic [11:0] H12     = 12'(RECT_H);
    localparam logic [11:0] STEP12  = 12'(STEP);
    localparam logic [10:0] STEP11  = 11'(STEP);
    localparam logic [10:0] INIT_X11 = 11'(INIT_X);
    localparam logic [10:0] INIT_Y11 = 11'(INIT_Y);

    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [1:0]  dir_q, dir_d;
    logic        vblnk_d;
    logic        tick;
    logic        in_rect;
    logic [11:0] rgb_d;
    logic [11:0] x12, y12, hc12, vc12;
    logic        left_q, up_q, left_d, up_d;

    assign x12  = {1'b0, x_q};
    assign y12  = {1'b0, y_q};
    assign hc12 = {1'b0, hcount_in};
    assign vc12 = {1'b0, vcount_in};

    // First cycle of vertical blank: move the rectangle while nothing is being drawn.
    assign tick = vblnk_in & ~vblnk_d;

    assign xpos = x_q;
    assign ypos = y_q;

    always_comb begin
        in_rect = (hc12 >= x12) && (hc12 < x12 + W12) &&
                  (vc12 >= y12) && (vc12 < y12 + H12);
        if (hblnk_in || vblnk_in) begin
            rgb_d = {r_in, g_in, b_in};
        end else if (in_rect) begin
            rgb_d = RECT_COLOR;
        end else begin
            rgb_d = {r_in, g_in, b_in};
        end
    end

    always_comb begin
        left_q = (dir_q == DOWN_LEFT) || (dir_q == UP_LEFT);
        up_q   = (dir_q == UP_RIGHT)  || (dir_q == UP_LEFT);
        left_d = left_q;
        up_d   = up_q;
        x_d    = x_q;
        y_d    = y_q;

        if (tick && enable) begin
            // X axis
            if (!left_q) begin
                if (x12 + STEP12 > X_MAX) begin
                    x_d    = X_MAX[10:0];
                    left_d = 1'b1;
                end else begin
                    x_d = x_q + STEP11;
                end
            end else begin
                if (x12 < STEP12) begin
                    x_d    = 11'd0;
                    left_d = 1'b0;
                end else begin
                    x_d = x_q - STEP11;
                end
            end

            // Y axis, down = increasing
            if (!up_q) begin
                if (y12 + STEP12 > Y_MAX) begin
                    y_d  = Y_MAX[10:0];
                    up_d = 1'b1;
                end else begin
                    y_d = y_q + STEP11;
                end
            end else begin
                if (y12 < STEP12) begin
                    y_d  = 11'd0;
                    up_d = 1'b0;
                end else begin
                    y_d = y_q - STEP11;
                end
            end
        end

        case ({up_d, left_d})
            2'b00:   dir_d = DOWN_RIGHT;
            2'b01:   dir_d = DOWN_LEFT;
            2'b10:   dir_d = UP_RIGHT;
            default: dir_d = UP_LEFT;
        endcase
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            r_out      <= '0;
            g_out      <= '0;
            b_out      <= '0;
            vblnk_d    <= 1'b0;
            x_q        <= INIT_X11;
            y_q        <= INIT_Y11;
            dir_q      <= DOWN_RIGHT;
        end else begin
            hcount_out <= hcount_in;
            hsync_out  <= hsync_in;
            hblnk_out  <= hblnk_in;
            vcount_out <= vcount_in;
            vsync_out  <= vsync_in;
            vblnk_out  <= vblnk_in;
            r_out      <= rgb_d[11:8];
            g_out      <= rgb_d[7:4];
            b_out      <= rgb_d[3:0];
            vblnk_d    <= vblnk_in;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
        end
    end

endmodule
